crc6_frame_checker: RTL and testbench
=====================================

Name: crc6_frame_checker

Overview:
- Receive-side counterpart of the crc_6 byte-wise CRC-6 generator.
- Accepts a byte stream framed by a last flag. Runs the CRC-6 over the payload bytes and compares the result against the trailing CRC byte.
- Reports one pass/fail result per frame and keeps saturating good/bad frame counters.
- Sits after the byte deserialiser, ahead of the frame consumer.

Parameters:
CRC_INIT, 6'h00, CRC register value at the start of every frame
MAX_LEN, 256, maximum payload bytes per frame (CRC byte excluded)
LEN_W, 9, width of the length field; must hold MAX_LEN
CNT_W, 16, width of the good/bad frame counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input byte valid
in_ready  out  1  checker can accept a byte
in_data  in  8  payload byte, or CRC byte when in_last=1
in_last  in  1  this byte is the frame's CRC byte
res_valid  out  1  frame result valid
res_ready  in  1  consumer accepts the result
res_ok  out  1  frame passed all checks
res_crc_err  out  1  CRC mismatch, or in_data[7:6] of the CRC byte nonzero
res_len_err  out  1  payload length 0 or greater than MAX_LEN
res_len  out  LEN_W  payload bytes counted, saturating at MAX_LEN+1
good_cnt  out  CNT_W  frames with res_ok=1, saturating
bad_cnt  out  CNT_W  frames with res_ok=0, saturating

Behaviour:
- Reset (async, immediate):
  - state=IDLE, crc=CRC_INIT, len=0.
  - res_valid=0, res_ok=0, res_crc_err=0, res_len_err=0, res_len=0.
  - good_cnt=0, bad_cnt=0, in_ready=1.
  - A partial frame in progress is discarded; no result is produced for it.
- Byte transfer happens when in_valid && in_ready.
- in_ready = !res_valid. The checker stalls the input only while a result is pending.
- Payload transfer (in_last=0):
  - crc <= crc6_update(in_data, crc), the same equations as the crc_6 generator.
  - len increments, saturating at MAX_LEN+1.
- CRC transfer (in_last=1):
  - crc_err = (in_data[5:0] != crc) || (in_data[7:6] != 0).
  - len_err = (len == 0) || (len > MAX_LEN).
- States:
  - IDLE: no byte of the current frame received yet.
    - Payload transfer -> ACCUM.
    - CRC transfer -> REPORT with len_err=1 (zero-length frame).
  - ACCUM: accumulating payload.
    - Payload transfer that takes len past MAX_LEN -> OVERRUN.
    - CRC transfer -> REPORT.
  - OVERRUN: bytes are consumed but the CRC is still updated (only length is flagged).
    - CRC transfer -> REPORT with len_err=1.
  - REPORT: on the clock edge of entry, register the outputs:
    - res_valid=1, res_crc_err, res_len_err.
    - res_ok = !crc_err && !len_err.
    - res_len = len.
    - On that same edge: crc and len reload to CRC_INIT and 0; increment good_cnt or bad_cnt.
    - Result stays stable until res_valid && res_ready; then res_valid=0 and state -> IDLE.
- Latency: res_valid rises on the edge that accepts the CRC byte, i.e. it is visible the cycle after that transfer. in_ready drops in that same cycle.
- Back-to-back frames: if res_ready=1 in the first result cycle, in_ready returns the following cycle. Sustained throughput is one bubble cycle per frame.
- Counters saturate at all-ones, never wrap. A result-field update and a counter increment never conflict, because only one result is produced per REPORT.
- in_valid=0 while in ACCUM: state held indefinitely; there is no timeout.
- in_data and in_last are ignored when in_valid=0.

Decomposition:
- Shared package crc6_pkg contains:
  - CRC6_W=6.
  - Default CRC6_INIT.
  - State enum {IDLE, ACCUM, OVERRUN, REPORT}.
  - crc6_update function (8-bit data, 6-bit crc -> 6-bit crc), shared with the generator so both ends cannot diverge.
- No sub-module is required. Optionally, the existing crc_6 block can be instantiated as the single combinational update sub-module instead of the function.

Test Plan:
- CRC_INIT=0; bytes 0x01, then 0x01 with last -> res_valid=1, res_ok=1, res_len=1, good_cnt=1.
- Payload 0x01, CRC byte 0x02 -> res_ok=0, res_crc_err=1, res_len_err=0, bad_cnt=1.
- Payload 0x01, 0x00, then CRC byte 0x0E -> pass, res_len=2. CRC byte 0x4E -> res_crc_err=1 (upper bits nonzero).
- Single byte 0x00 with last (zero payload) -> res_len_err=1, res_ok=0. Also MAX_LEN+1 payload bytes, then a correct CRC -> res_len_err=1, res_crc_err=0, res_len=MAX_LEN+1.
- Hold res_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, result fields stable, no bytes consumed. Raise res_ready -> next frame is accepted the cycle after the handshake.
- Assert rst midway through a 3-byte payload -> all outputs return to reset values immediately. The following clean frame 0x01 / 0x01 passes with res_len=1.

Source files
------------

// File: rtl/crc6_pkg.sv
// Shared CRC-6 definitions used by both the crc_6 generator and the frame checker,
// so the two ends of the link always run identical update equations.
package crc6_pkg;

    localparam int unsigned CRC6_W = 6;
    localparam logic [CRC6_W-1:0] CRC6_INIT = 6'h00;

    // Generator polynomial x^6 + x^5 + x^4 + x^3 + x^2 + 1, leading term implied.
    localparam logic [CRC6_W-1:0] CRC6_POLY = 6'h3D;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OVERRUN,
        REPORT
    } state_e;

    // Bits enter MSB first at the bottom of the register; the bit shifted out
    // of the top decides whether the polynomial is folded back in.
    function automatic logic [CRC6_W-1:0] crc6_update(
        input logic [7:0]        data,
        input logic [CRC6_W-1:0] crc
    );
        logic [CRC6_W-1:0] c;
        logic              fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC6_W-1];
            c  = {c[CRC6_W-2:0], data[i]};
            if (fb) begin
                c = c ^ CRC6_POLY;
            end
        end
        return c;
    endfunction

    // A CRC byte only matches when its unused top bits are clear as well.
    function automatic logic crc6_mismatch(
        input logic [7:0]        crc_byte,
        input logic [CRC6_W-1:0] crc
    );
        return (crc_byte[CRC6_W-1:0] != crc) || (crc_byte[7:CRC6_W] != '0);
    endfunction

endpackage

// File: rtl/crc6_frame_checker_if.sv
// Byte-stream input and per-frame result channel of the CRC-6 frame checker,
// plus the running good/bad frame statistics.
interface crc6_frame_checker_if #(
    parameter int unsigned LEN_W = 9,
    parameter int unsigned CNT_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;

    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_crc_err;
    logic             res_len_err;
    logic [LEN_W-1:0] res_len;

    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_ok, res_crc_err, res_len_err, res_len,
        input  good_cnt, bad_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_ok, res_crc_err, res_len_err, res_len,
        output good_cnt, bad_cnt
    );

endinterface

// File: rtl/crc6_frame_checker_stats.sv
// Saturating good/bad frame counters; each bumps by one on its increment pulse
// and sticks at all-ones instead of wrapping.
module crc6_frame_checker_stats #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_good,
    input  logic             inc_bad,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q,  bad_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        good_d = good_q;
        bad_d  = bad_q;
        if (inc_good && (good_q != '1)) begin
            good_d = good_q + CNT_W'(1);
        end
        if (inc_bad && (bad_q != '1)) begin
            bad_d = bad_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;

endmodule

// File: rtl/crc6_frame_checker.sv
// Receive-side CRC-6 frame checker: runs the CRC over payload bytes, compares it
// with the trailing CRC byte and reports one pass/fail result per frame.
module crc6_frame_checker
    import crc6_pkg::*;
#(
    parameter logic [CRC6_W-1:0] CRC_INIT = CRC6_INIT,
    parameter int unsigned       MAX_LEN  = 256,
    parameter int unsigned       LEN_W    = 9,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    crc6_frame_checker_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    state_e            state_q, state_d;
    logic [CRC6_W-1:0] crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic              res_ok_q,      res_ok_d;
    logic              res_crc_err_q, res_crc_err_d;
    logic              res_len_err_q, res_len_err_d;
    logic [LEN_W-1:0]  res_len_q,     res_len_d;

    logic              res_valid;
    logic              in_ready;
    logic              xfer;
    logic [LEN_W-1:0]  len_inc;
    logic              crc_err;
    logic              len_err;
    logic              frame_ok;
    logic              inc_good;
    logic              inc_bad;

    // A result is pending exactly while in REPORT; input stalls only then.
    assign res_valid = (state_q == REPORT);
    assign in_ready  = !res_valid;
    assign xfer      = bus.in_valid && in_ready;

    assign len_inc  = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    assign crc_err  = crc6_mismatch(bus.in_data, crc_q);
    assign len_err  = (len_q == '0) || (len_q > LEN_MAX);
    assign frame_ok = !crc_err && !len_err;

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        res_ok_d      = res_ok_q;
        res_crc_err_d = res_crc_err_q;
        res_len_err_d = res_len_err_q;
        res_len_d     = res_len_q;
        inc_good      = 1'b0;
        inc_bad       = 1'b0;

        case (state_q)
            IDLE, ACCUM, OVERRUN: begin
                if (xfer) begin
                    if (bus.in_last) begin
                        state_d       = REPORT;
                        res_ok_d      = frame_ok;
                        res_crc_err_d = crc_err;
                        res_len_err_d = len_err;
                        res_len_d     = len_q;
                        crc_d         = CRC_INIT;
                        len_d         = '0;
                        inc_good      = frame_ok;
                        inc_bad       = !frame_ok;
                    end else begin
                        // Overrun frames keep updating the CRC; only length is flagged.
                        crc_d   = crc6_update(bus.in_data, crc_q);
                        len_d   = len_inc;
                        state_d = (len_inc > LEN_MAX) ? OVERRUN : ACCUM;
                    end
                end
            end
            REPORT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            crc_q         <= CRC_INIT;
            len_q         <= '0;
            res_ok_q      <= 1'b0;
            res_crc_err_q <= 1'b0;
            res_len_err_q <= 1'b0;
            res_len_q     <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            res_ok_q      <= res_ok_d;
            res_crc_err_q <= res_crc_err_d;
            res_len_err_q <= res_len_err_d;
            res_len_q     <= res_len_d;
        end
    end

    crc6_frame_checker_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .inc_good (inc_good),
        .inc_bad  (inc_bad),
        .good_cnt (bus.good_cnt),
        .bad_cnt  (bus.bad_cnt)
    );

    assign bus.in_ready    = in_ready;
    assign bus.res_valid   = res_valid;
    assign bus.res_ok      = res_ok_q;
    assign bus.res_crc_err = res_crc_err_q;
    assign bus.res_len_err = res_len_err_q;
    assign bus.res_len     = res_len_q;

endmodule

// File: tb/tb_crc6_frame_checker.sv
// Self-checking bench for crc6_frame_checker: table-driven frames, model-driven
// random and long frames, plus hand-written stall and mid-frame reset sequences.
module tb_crc6_frame_checker;

    localparam int MAX_LEN = 256;
    localparam int LEN_W   = 9;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc6_frame_checker_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    crc6_frame_checker #(
        .CRC_INIT (6'h00),
        .MAX_LEN  (MAX_LEN),
        .LEN_W    (LEN_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic ok;
        logic crc_err;
        logic len_err;
        int   len;
        int   good;
        int   bad;
    } exp_t;

    typedef struct {
        int          n;
        logic [31:0] pl;        // payload byte k sits at pl[8k +: 8]
        logic [7:0]  crc_byte;
        logic        ok;
        logic        crc_err;
        logic        len_err;
        int          len;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_good = 0;
    int   model_bad  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference CRC by polynomial long division over the whole message.
    function automatic logic [5:0] model_crc(input logic [7:0] msg[$]);
        logic [6:0] r;
        r = 7'h00;
        foreach (msg[k]) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[5:0], msg[k][b]};
                if (r[6]) r = r ^ 7'h7D;
            end
        end
        return r[5:0];
    endfunction

    task automatic push_expect(input logic ok, input logic ce, input logic le, input int len);
        exp_t e;
        if (ok) model_good++;
        else    model_bad++;
        e.ok = ok; e.crc_err = ce; e.len_err = le; e.len = len;
        e.good = model_good; e.bad = model_bad;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input logic [7:0] msg[$], input logic [7:0] crc_byte);
        logic ce, le;
        int   n;
        n  = msg.size();
        ce = (crc_byte[5:0] != model_crc(msg)) || (crc_byte[7:6] != 2'b00);
        le = (n == 0) || (n > MAX_LEN);
        push_expect(!ce && !le, ce, le, (n > MAX_LEN + 1) ? MAX_LEN + 1 : n);
    endtask

    // Entered and left at posedge+1; the byte moves on the first edge with in_ready high.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            guard++;
            if (guard > 100) begin
                check("in_ready_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] msg[$], input logic [7:0] crc_byte);
        foreach (msg[k]) send_byte(msg[k], 1'b0);
        send_byte(crc_byte, 1'b1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("result_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each result on the cycle its handshake completes.
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(bus.res_len), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_ok",      32'(bus.res_ok),      32'(mon_e.ok));
                check("res_crc_err", 32'(bus.res_crc_err), 32'(mon_e.crc_err));
                check("res_len_err", 32'(bus.res_len_err), 32'(mon_e.len_err));
                check("res_len",     32'(bus.res_len),     32'(mon_e.len));
                check("good_cnt",    32'(bus.good_cnt),    32'(mon_e.good));
                check("bad_cnt",     32'(bus.bad_cnt),     32'(mon_e.bad));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] msg[$];
        logic [5:0] c;
        logic [7:0] cb;
        int         n;

        vecs[0] = '{1, 32'h0000_0001, 8'h01, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{1, 32'h0000_0001, 8'h02, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{2, 32'h0000_0001, 8'h0E, 1'b1, 1'b0, 1'b0, 2};
        vecs[3] = '{2, 32'h0000_0001, 8'h4E, 1'b0, 1'b1, 1'b0, 2};
        vecs[4] = '{0, 32'h0000_0000, 8'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{0, 32'h0000_0000, 8'h05, 1'b0, 1'b1, 1'b1, 0};
        vecs[6] = '{1, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 1'b0, 1};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);
        check("rst_res_valid",   32'(bus.res_valid),   32'd0);
        check("rst_res_ok",      32'(bus.res_ok),      32'd0);
        check("rst_res_len",     32'(bus.res_len),     32'd0);
        check("rst_good_cnt",    32'(bus.good_cnt),    32'd0);
        check("rst_bad_cnt",     32'(bus.bad_cnt),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            msg.delete();
            for (int k = 0; k < vecs[i].n; k++) msg.push_back(vecs[i].pl[8*k +: 8]);
            push_expect(vecs[i].ok, vecs[i].crc_err, vecs[i].len_err, vecs[i].len);
            send_frame(msg, vecs[i].crc_byte);
        end
        drain();

        // Random frames, every other one with a corrupted CRC byte.
        for (int r = 0; r < 6; r++) begin
            msg.delete();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) msg.push_back(8'($urandom_range(0, 255)));
            c  = model_crc(msg);
            cb = {2'b00, c};
            if (r % 2 == 1) cb = cb ^ ((r == 3) ? 8'h80 : 8'h04);
            push_model(msg, cb);
            send_frame(msg, cb);
        end
        drain();

        // Length boundaries: MAX_LEN, MAX_LEN+1 and a long overrun, all with correct CRC.
        foreach (vecs[i]) begin end
        for (int t = 0; t < 3; t++) begin
            msg.delete();
            n = (t == 0) ? MAX_LEN : (t == 1) ? MAX_LEN + 1 : MAX_LEN + 44;
            for (int k = 0; k < n; k++) msg.push_back(8'((k * 37 + t) & 8'hFF));
            cb = {2'b00, model_crc(msg)};
            push_model(msg, cb);
            send_frame(msg, cb);
        end
        drain();

        // Stall: result held with res_ready low while a new byte waits.
        bus.res_ready = 1'b0;
        push_expect(1'b1, 1'b0, 1'b0, 1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("lat_res_valid", 32'(bus.res_valid), 32'd1);
        check("lat_in_ready",  32'(bus.in_ready),  32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_res_valid", 32'(bus.res_valid), 32'd1);
            check("stall_res_ok",    32'(bus.res_ok),    32'd1);
            check("stall_res_len",   32'(bus.res_len),   32'd1);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("hs_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hs_res_valid", 32'(bus.res_valid), 32'd0);
        check("after_hs_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        bus.in_last = 1'b1;
        push_expect(1'b1, 1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("b2b_res_valid", 32'(bus.res_valid), 32'd1);
        drain();

        // Reset midway through a 3-byte payload must clear everything at once.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hCC;
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",    32'(bus.in_ready),    32'd1);
        check("arst_res_valid",   32'(bus.res_valid),   32'd0);
        check("arst_res_ok",      32'(bus.res_ok),      32'd0);
        check("arst_res_crc_err", 32'(bus.res_crc_err), 32'd0);
        check("arst_res_len_err", 32'(bus.res_len_err), 32'd0);
        check("arst_res_len",     32'(bus.res_len),     32'd0);
        check("arst_good_cnt",    32'(bus.good_cnt),    32'd0);
        check("arst_bad_cnt",     32'(bus.bad_cnt),     32'd0);
        bus.in_valid = 1'b0;
        model_good = 0;
        model_bad  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        msg.delete();
        msg.push_back(8'h01);
        push_expect(1'b1, 1'b0, 1'b0, 1);
        send_frame(msg, 8'h01);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
